axi4_lite_rr_master: RTL and testbench

//  Round-robin scheduler sharing one AXI4-Lite slave (the 8x32 register bank) among NREQ

---
 rtl/axi4_lite_rr_master_if.sv | 30 +++
 rtl/axi4_lite_rr_master.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_axi4_lite_rr_master.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_rr_master_if.sv
// AXI4-Lite bus bundle between the round-robin master and its register-bank slave.
interface axi4_lite_rr_master_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_rr_master.sv
// Round-robin scheduler sharing one AXI4-Lite slave among NREQ single-command requesters.
// One transaction at a time; completion is reported with a one-cycle req_ack pulse.
module axi4_lite_rr_master #(
    parameter int NREQ = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ*4-1:0]    req_wstrb,
    output logic [NREQ-1:0]      req_ack,
    output logic [31:0]          req_rdata,
    output logic [1:0]           req_resp,
    output logic [1:0]           grant,
    output logic                 busy,
    axi4_lite_rr_master_if.master axi
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_ACK     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    grant_q, grant_d;
    logic          busy_q, busy_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic [31:0]   req_rdata_q, req_rdata_d;
    logic [1:0]    req_resp_q, req_resp_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic          awvalid_q, awvalid_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic [31:0]   araddr_q, araddr_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;

    logic [3:0]    req_ext_s;
    logic [3:0]    we_ext_s;
    logic [31:0]   addr_a_s  [4];
    logic [31:0]   wdata_a_s [4];
    logic [3:0]    wstrb_a_s [4];
    logic          sel_found_s;
    logic [1:0]    sel_idx_s;
    logic [2:0]    sel_pos_s;
    logic          aw_fin_s;
    logic          w_fin_s;
    logic [3:0]    ack_sel_s;

    assign req_ext_s = 4'(req);
    assign we_ext_s  = 4'(req_we);

    // Unused requester slots read as zero so the selected index can always address 4 entries.
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        if (gi < NREQ) begin : g_on
            assign addr_a_s[gi]  = req_addr[32*gi +: 32];
            assign wdata_a_s[gi] = req_wdata[32*gi +: 32];
            assign wstrb_a_s[gi] = req_wstrb[4*gi +: 4];
        end else begin : g_off
            assign addr_a_s[gi]  = 32'd0;
            assign wdata_a_s[gi] = 32'd0;
            assign wstrb_a_s[gi] = 4'd0;
        end
    end

    // Round-robin search: walk from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = 2'd0;
        sel_pos_s   = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sel_pos_s = 3'(ptr_q) + 3'(k);
            if (sel_pos_s >= 3'(NREQ)) begin
                sel_pos_s = sel_pos_s - 3'(NREQ);
            end else begin
                sel_pos_s = sel_pos_s;
            end
            if (req_ext_s[sel_pos_s[1:0]]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = sel_pos_s[1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    assign aw_fin_s  = !awvalid_q || axi.AWREADY;
    assign w_fin_s   = !wvalid_q  || axi.WREADY;
    assign ack_sel_s = 4'b0001 << grant_q;

    // State and all registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            ptr_q       <= 2'd0;
            grant_q     <= 2'd0;
            busy_q      <= 1'b0;
            req_ack_q   <= '0;
            req_rdata_q <= 32'd0;
            req_resp_q  <= 2'd0;
            awaddr_q    <= 32'd0;
            awvalid_q   <= 1'b0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= 32'd0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            req_ack_q   <= req_ack_d;
            req_rdata_q <= req_rdata_d;
            req_resp_q  <= req_resp_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found_s) begin
                    if (we_ext_s[sel_idx_s]) begin
                        state_d = S_WR_AW_W;
                    end else begin
                        state_d = S_RD_AR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_AW_W: begin
                if (aw_fin_s && w_fin_s) begin
                    state_d = S_WR_B;
                end else begin
                    state_d = S_WR_AW_W;
                end
            end
            S_WR_B: begin
                if (bready_q && axi.BVALID) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_WR_B;
                end
            end
            S_RD_AR: begin
                if (arvalid_q && axi.ARREADY) begin
                    state_d = S_RD_R;
                end else begin
                    state_d = S_RD_AR;
                end
            end
            S_RD_R: begin
                if (rready_q && axi.RVALID) begin
                    state_d = S_ACK;
                end else begin
                    state_d = S_RD_R;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic; every output is the next value of its flop.
    always_comb begin
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        req_ack_d   = '0;
        req_rdata_d = req_rdata_q;
        req_resp_d  = req_resp_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found_s) begin
                    grant_d = sel_idx_s;
                    busy_d  = 1'b1;
                    if (we_ext_s[sel_idx_s]) begin
                        awaddr_d  = addr_a_s[sel_idx_s];
                        wdata_d   = wdata_a_s[sel_idx_s];
                        wstrb_d   = wstrb_a_s[sel_idx_s];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        araddr_d  = addr_a_s[sel_idx_s];
                        arvalid_d = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_WR_AW_W: begin
                // Each channel retires on its own handshake and is never raised again.
                if (awvalid_q && axi.AWREADY) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && axi.WREADY) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_fin_s && w_fin_s) begin
                    bready_d = 1'b1;
                end else begin
                    bready_d = bready_q;
                end
            end
            S_WR_B: begin
                if (bready_q && axi.BVALID) begin
                    bready_d    = 1'b0;
                    req_resp_d  = axi.BRESP;
                    req_rdata_d = 32'd0;
                    req_ack_d   = ack_sel_s[NREQ-1:0];
                end else begin
                    bready_d = bready_q;
                end
            end
            S_RD_AR: begin
                if (arvalid_q && axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    arvalid_d = arvalid_q;
                end
            end
            S_RD_R: begin
                if (rready_q && axi.RVALID) begin
                    rready_d    = 1'b0;
                    req_rdata_d = axi.RDATA;
                    req_resp_d  = axi.RRESP;
                    req_ack_d   = ack_sel_s[NREQ-1:0];
                end else begin
                    rready_d = rready_q;
                end
            end
            S_ACK: begin
                busy_d = 1'b0;
                if (grant_q == 2'(NREQ - 1)) begin
                    ptr_d = 2'd0;
                end else begin
                    ptr_d = grant_q + 2'd1;
                end
            end
            default: begin
                busy_d    = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    assign req_ack     = req_ack_q;
    assign req_rdata   = req_rdata_q;
    assign req_resp    = req_resp_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign axi.AWADDR  = awaddr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = araddr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_rr_master.sv
// Scoreboard bench: requester commands push expected results, req_ack pops and compares.
// Includes an 8x32 register-bank slave with programmable ready delays.
module tb_axi4_lite_rr_master;

    localparam int NREQ = 2;

    logic                ACLK;
    logic                ARESETN;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_we;
    logic [NREQ*32-1:0]  req_addr;
    logic [NREQ*32-1:0]  req_wdata;
    logic [NREQ*4-1:0]   req_wstrb;
    logic [NREQ-1:0]     req_ack;
    logic [31:0]         req_rdata;
    logic [1:0]          req_resp;
    logic [1:0]          grant;
    logic                busy;

    axi4_lite_rr_master_if axi_if ();

    axi4_lite_rr_master #(.NREQ(NREQ)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .req_resp  (req_resp),
        .grant     (grant),
        .busy      (busy),
        .axi       (axi_if)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Slave model
    int          aw_delay, w_delay, ar_delay;
    logic        b_hold;
    int          aw_cnt, w_cnt, ar_cnt;
    int          aw_hs, w_hs;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_l, w_data_l;
    logic [3:0]  w_strb_l;
    logic        bvalid_r, rvalid_r;
    logic [1:0]  bresp_r, rresp_r;
    logic [31:0] rdata_r;
    logic [31:0] bank [8];

    assign axi_if.AWREADY = axi_if.AWVALID && (aw_cnt >= aw_delay);
    assign axi_if.WREADY  = axi_if.WVALID  && (w_cnt  >= w_delay);
    assign axi_if.ARREADY = axi_if.ARVALID && (ar_cnt >= ar_delay);
    assign axi_if.BVALID  = bvalid_r;
    assign axi_if.BRESP   = bresp_r;
    assign axi_if.RVALID  = rvalid_r;
    assign axi_if.RDATA   = rdata_r;
    assign axi_if.RRESP   = rresp_r;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_hs <= 0; w_hs <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_addr_l <= 32'd0; w_data_l <= 32'd0;
            w_strb_l <= 4'd0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
            bresp_r <= 2'd0; rresp_r <= 2'd0; rdata_r <= 32'd0;
        end else begin
            if (axi_if.AWVALID && !axi_if.AWREADY) aw_cnt <= aw_cnt + 1;
            if (axi_if.AWVALID && axi_if.AWREADY) begin
                aw_cnt <= 0; aw_got <= 1'b1; aw_addr_l <= axi_if.AWADDR; aw_hs <= aw_hs + 1;
            end
            if (axi_if.WVALID && !axi_if.WREADY) w_cnt <= w_cnt + 1;
            if (axi_if.WVALID && axi_if.WREADY) begin
                w_cnt <= 0; w_got <= 1'b1; w_data_l <= axi_if.WDATA; w_strb_l <= axi_if.WSTRB;
                w_hs <= w_hs + 1;
            end
            if (aw_got && w_got && !bvalid_r && !b_hold) begin
                bvalid_r <= 1'b1;
                if (aw_addr_l[31:5] == 27'd0) begin
                    for (int b = 0; b < 4; b++)
                        if (w_strb_l[b]) bank[aw_addr_l[4:2]][8*b +: 8] <= w_data_l[8*b +: 8];
                    bresp_r <= 2'b00;
                end else begin
                    bresp_r <= 2'b10;
                end
            end
            if (bvalid_r && axi_if.BREADY) begin
                bvalid_r <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (axi_if.ARVALID && !axi_if.ARREADY) ar_cnt <= ar_cnt + 1;
            if (axi_if.ARVALID && axi_if.ARREADY) begin
                ar_cnt   <= 0;
                rvalid_r <= 1'b1;
                if (axi_if.ARADDR[31:5] == 27'd0) begin
                    rdata_r <= bank[axi_if.ARADDR[4:2]]; rresp_r <= 2'b00;
                end else begin
                    rdata_r <= 32'd0; rresp_r <= 2'b10;
                end
            end
            if (rvalid_r && axi_if.RREADY) rvalid_r <= 1'b0;
        end
    end

    // Scoreboard and reference register model
    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model_mem [8];
    int          n_checks;
    int          n_errors;
    int          ar_cyc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic issue(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        logic ok;
        ok    = (addr[31:5] == 27'd0);
        e.idx = idx;
        if (we) begin
            if (ok)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[addr[4:2]][8*b +: 8] = data[8*b +: 8];
            e.rdata = 32'd0;
            e.resp  = ok ? 2'b00 : 2'b10;
        end else begin
            e.rdata = ok ? model_mem[addr[4:2]] : 32'd0;
            e.resp  = ok ? 2'b00 : 2'b10;
        end
        exp_q.push_back(e);
        req_we[idx]            = we;
        req_addr[32*idx +: 32] = addr;
        req_wdata[32*idx +: 32] = data;
        req_wstrb[4*idx +: 4]  = strb;
        req[idx]               = 1'b1;
    endtask

    // Run until n acks arrive (or budget expires), checking each ack and AXI channel rules.
    task automatic wait_acks(input int n, input int budget);
        int          got_n;
        int          cyc;
        exp_t        e;
        logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        got_n = 0; cyc = 0;
        p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_arv = 1'b0; p_arr = 1'b0;
        p_awaddr = 32'd0; p_wdata = 32'd0; p_araddr = 32'd0; p_wstrb = 4'd0;
        while (got_n < n && cyc < budget) begin
            @(negedge ACLK);
            cyc++;
            if (axi_if.ARVALID) ar_cyc++;
            if (p_awv && !p_awr) check_val("aw_hold", {axi_if.AWVALID, axi_if.AWADDR}, {1'b1, p_awaddr});
            if (p_awv && p_awr)  check_val("aw_drop", 64'(axi_if.AWVALID), 64'd0);
            if (p_wv && !p_wr)   check_val("w_hold", {axi_if.WVALID, axi_if.WSTRB, axi_if.WDATA}, {1'b1, p_wstrb, p_wdata});
            if (p_wv && p_wr)    check_val("w_drop", 64'(axi_if.WVALID), 64'd0);
            if (p_arv && !p_arr) check_val("ar_hold", {axi_if.ARVALID, axi_if.ARADDR}, {1'b1, p_araddr});
            if (axi_if.RREADY)   check_val("rready_after_ar", 64'(axi_if.ARVALID), 64'd0);
            if (|req_ack) begin
                check_val("ack_onehot", 64'($countones(req_ack)), 64'd1);
                check_val("busy_at_ack", 64'(busy), 64'd1);
                if (exp_q.size() == 0) begin
                    check_val("ack_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("ack_idx", 64'(onehot_idx(req_ack)), 64'(e.idx));
                    check_val("grant_at_ack", 64'(grant), 64'(e.idx));
                    check_val("rdata", 64'(req_rdata), 64'(e.rdata));
                    check_val("resp", 64'(req_resp), 64'(e.resp));
                end
                req   = req & ~req_ack;
                got_n++;
            end
            p_awv = axi_if.AWVALID; p_awr = axi_if.AWREADY; p_awaddr = axi_if.AWADDR;
            p_wv  = axi_if.WVALID;  p_wr  = axi_if.WREADY;  p_wdata  = axi_if.WDATA;
            p_wstrb = axi_if.WSTRB;
            p_arv = axi_if.ARVALID; p_arr = axi_if.ARREADY; p_araddr = axi_if.ARADDR;
        end
        if (got_n < n) check_val("ack_timeout", 64'(got_n), 64'(n));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_ctrl"}, 64'({req_ack, busy, grant, req_resp, axi_if.AWVALID, axi_if.WVALID,
                                      axi_if.BREADY, axi_if.ARVALID, axi_if.RREADY}), 64'd0);
        check_val({tag, "_rdata"}, 64'(req_rdata), 64'd0);
        check_val({tag, "_awaddr"}, 64'(axi_if.AWADDR), 64'd0);
        check_val({tag, "_wdata"}, 64'({axi_if.WSTRB, axi_if.WDATA}), 64'd0);
        check_val({tag, "_araddr"}, 64'(axi_if.ARADDR), 64'd0);
    endtask

    initial begin
        int aw_base, w_base, stray, bwait;
        n_checks = 0; n_errors = 0; ar_cyc = 0;
        ARESETN = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        aw_delay = 0; w_delay = 0; ar_delay = 0; b_hold = 1'b0;
        for (int i = 0; i < 8; i++) model_mem[i] = 32'd0;
        repeat (3) @(negedge ACLK);
        check_outputs_zero("reset");
        ARESETN = 1'b1;
        @(negedge ACLK);

        // T1: write then read back through the other requester
        aw_base = aw_hs; w_base = w_hs;
        issue(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        wait_acks(1, 100);
        check_val("t1_aw_count", 64'(aw_hs - aw_base), 64'd1);
        check_val("t1_w_count", 64'(w_hs - w_base), 64'd1);
        issue(1, 1'b0, 32'h4, 32'd0, 4'd0);
        wait_acks(1, 100);

        // T2: both requesters held, twice; pointer has wrapped back to 0
        issue(0, 1'b1, 32'h8, 32'h11112222, 4'hF);
        issue(1, 1'b1, 32'hC, 32'h33334444, 4'hF);
        wait_acks(2, 200);
        issue(0, 1'b0, 32'h8, 32'd0, 4'd0);
        issue(1, 1'b0, 32'hC, 32'd0, 4'd0);
        wait_acks(2, 200);

        // T3: W channel accepted three cycles after AW; partial strobe
        w_delay = 3;
        aw_base = aw_hs; w_base = w_hs;
        issue(0, 1'b1, 32'h10, 32'hCAFEF00D, 4'b0011);
        wait_acks(1, 100);
        check_val("t3_aw_count", 64'(aw_hs - aw_base), 64'd1);
        check_val("t3_w_count", 64'(w_hs - w_base), 64'd1);
        w_delay = 0;
        issue(1, 1'b0, 32'h10, 32'd0, 4'd0);
        wait_acks(1, 100);

        // T4: out-of-range address returns SLVERR for read and write
        issue(1, 1'b0, 32'h100, 32'd0, 4'd0);
        wait_acks(1, 100);
        issue(0, 1'b1, 32'h100, 32'h55AA55AA, 4'hF);
        wait_acks(1, 100);

        // T5: ARREADY withheld for 5 cycles
        ar_delay = 5;
        ar_cyc   = 0;
        issue(0, 1'b0, 32'h4, 32'd0, 4'd0);
        wait_acks(1, 100);
        check_val("t5_arvalid_cycles", 64'(ar_cyc), 64'd6);
        ar_delay = 0;

        // T6: reset while waiting in WR_B (pointer was 1 before it)
        b_hold = 1'b1;
        issue(1, 1'b1, 32'h1C, 32'h0BADF00D, 4'hF);
        bwait = 0;
        while (!axi_if.BREADY && bwait < 50) begin
            @(negedge ACLK);
            bwait++;
        end
        check_val("t6_reached_wr_b", 64'(axi_if.BREADY), 64'd1);
        #2 ARESETN = 1'b0;
        #1 check_outputs_zero("t6_reset");
        exp_q.delete();
        req    = '0;
        b_hold = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        stray = 0;
        repeat (5) begin
            @(negedge ACLK);
            if (|req_ack) stray++;
        end
        check_val("t6_stray_ack", 64'(stray), 64'd0);
        issue(0, 1'b1, 32'h18, 32'h12345678, 4'hF);
        issue(1, 1'b1, 32'h14, 32'h9ABCDEF0, 4'hF);
        wait_acks(2, 200);
        issue(0, 1'b0, 32'h18, 32'd0, 4'd0);
        wait_acks(1, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
